// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts a two-source request, reads the register file,
// resolves PC-relative and writeback-forwarded operands, and holds the result
// until the consumer accepts it. Writebacks are snooped while holding.
module operand_fetch #(
  parameter int BIT_WIDTH    = 32,
  parameter int REG_COUNT_L2 = 4,
  parameter int REG_PC_INDEX = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_COUNT_L2-1:0] in_rn,
  input  logic [REG_COUNT_L2-1:0] in_rm,
  input  logic [BIT_WIDTH-1:0]    in_pc,
  input  logic [BIT_WIDTH-1:0]    in_tag,
  output logic [REG_COUNT_L2-1:0] rf_read_addr1,
  output logic [REG_COUNT_L2-1:0] rf_read_addr2,
  input  logic [BIT_WIDTH-1:0]    rf_read_value1,
  input  logic [BIT_WIDTH-1:0]    rf_read_value2,
  input  logic                    wb_enable,
  input  logic [REG_COUNT_L2-1:0] wb_addr,
  input  logic [BIT_WIDTH-1:0]    wb_value,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIT_WIDTH-1:0]    out_op1,
  output logic [BIT_WIDTH-1:0]    out_op2,
  output logic [BIT_WIDTH-1:0]    out_tag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [REG_COUNT_L2-1:0] PC_IDX   = REG_COUNT_L2'(REG_PC_INDEX);
  localparam logic [BIT_WIDTH-1:0]    PC_AHEAD = BIT_WIDTH'(8);

  logic [1:0]              state_q, state_d;
  logic [REG_COUNT_L2-1:0] rn_q, rn_d, rm_q, rm_d;
  logic [BIT_WIDTH-1:0]    pc_q, pc_d, tag_q, tag_d;
  logic [BIT_WIDTH-1:0]    op1_q, op1_d, op2_q, op2_d, out_tag_q, out_tag_d;
  logic                    accept;

  // A writeback is forwarded only when it targets the index and the index is not the PC.
  function automatic logic wb_hits(input logic                    en,
                                   input logic [REG_COUNT_L2-1:0] waddr,
                                   input logic [REG_COUNT_L2-1:0] idx);
    return en && (waddr == idx) && (idx != PC_IDX);
  endfunction

  // Operand priority: PC reads see pc+8, then a same-cycle writeback, then the register file.
  function automatic logic [BIT_WIDTH-1:0] select_operand(
      input logic [REG_COUNT_L2-1:0] idx,
      input logic [BIT_WIDTH-1:0]    pc,
      input logic                    en,
      input logic [REG_COUNT_L2-1:0] waddr,
      input logic [BIT_WIDTH-1:0]    wval,
      input logic [BIT_WIDTH-1:0]    rfv);
    if (idx == PC_IDX)               return pc + PC_AHEAD;
    else if (wb_hits(en, waddr, idx)) return wval;
    else                             return rfv;
  endfunction

  // Handshake: a new request is taken when idle or when the held result drains this cycle.
  always_comb begin
    in_ready = !reset && !flush &&
               ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
    accept   = in_valid && in_ready;
  end

  // Register-file addresses come straight from the request on accept, else stay on the last request.
  always_comb begin
    rf_read_addr1 = accept ? in_rn : rn_q;
    rf_read_addr2 = accept ? in_rm : rm_q;
  end

  // Next-state and datapath updates; flush wins over accept and drain.
  always_comb begin
    state_d   = state_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    pc_d      = pc_q;
    tag_d     = tag_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    out_tag_d = out_tag_q;

    if (accept) begin
      rn_d  = in_rn;
      rm_d  = in_rm;
      pc_d  = in_pc;
      tag_d = in_tag;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_READ;
      end
      S_READ: begin
        op1_d     = select_operand(rn_q, pc_q, wb_enable, wb_addr, wb_value, rf_read_value1);
        op2_d     = select_operand(rm_q, pc_q, wb_enable, wb_addr, wb_value, rf_read_value2);
        out_tag_d = tag_q;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (wb_hits(wb_enable, wb_addr, rn_q)) op1_d = wb_value;
        if (wb_hits(wb_enable, wb_addr, rm_q)) op2_d = wb_value;
        if (out_ready) state_d = accept ? S_READ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  // State and data registers; reset clears everything so addresses and outputs read zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rn_q      <= '0;
      rm_q      <= '0;
      pc_q      <= '0;
      tag_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      rn_q      <= rn_d;
      rm_q      <= rm_d;
      pc_q      <= pc_d;
      tag_q     <= tag_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      out_tag_q <= out_tag_d;
    end
  end

  // Outputs are presented only while holding a completed fetch.
  always_comb begin
    out_valid = (state_q == S_HOLD);
    out_op1   = op1_q;
    out_op2   = op2_q;
    out_tag   = out_tag_q;
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [3:0]  in_rn, in_rm, rf_read_addr1, rf_read_addr2, wb_addr;
  logic [31:0] in_pc, in_tag, rf_read_value1, rf_read_value2, wb_value;
  logic        wb_enable, out_valid, out_ready;
  logic [31:0] out_op1, out_op2, out_tag;

  int errors = 0;
  int checks = 0;

  operand_fetch #(.BIT_WIDTH(32), .REG_COUNT_L2(4), .REG_PC_INDEX(15)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_pc(in_pc), .in_tag(in_tag),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_value1(rf_read_value1), .rf_read_value2(rf_read_value2),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_value(wb_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    flush = 0; in_valid = 0; out_ready = 0; wb_enable = 0;
    wb_addr = 0; wb_value = 0; rf_read_value1 = 0; rf_read_value2 = 0;
  endtask

  task automatic request(input logic [3:0] rn, input logic [3:0] rm,
                         input logic [31:0] pc, input logic [31:0] tag);
    in_valid = 1; in_rn = rn; in_rm = rm; in_pc = pc; in_tag = tag;
  endtask

  task automatic test_reset();
    quiet(); in_rn = 0; in_rm = 0; in_pc = 0; in_tag = 0;
    reset = 1;
    tick(); tick();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    tick();
    reset = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_after_in_ready got=%b exp=1", in_ready); end
    checks++; if (rf_read_addr1 !== 4'd0 || rf_read_addr2 !== 4'd0) begin errors++; $display("FAIL rst_addr got=%h/%h exp=0/0", rf_read_addr1, rf_read_addr2); end
    checks++; if (out_op1 !== 32'd0 || out_op2 !== 32'd0 || out_tag !== 32'd0) begin errors++; $display("FAIL rst_outputs got=%h/%h/%h exp=0", out_op1, out_op2, out_tag); end
    tick();
  endtask

  task automatic test_basic();
    quiet(); request(4'd3, 4'd5, 32'h200, 32'hCAFE);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    checks++; if (rf_read_addr1 !== 4'd3 || rf_read_addr2 !== 4'd5) begin errors++; $display("FAIL basic_addr got=%h/%h exp=3/5", rf_read_addr1, rf_read_addr2); end
    tick();
    in_valid = 0; in_rn = 4'd9; in_rm = 4'd9; rf_read_value1 = 32'h11; rf_read_value2 = 32'h22;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_read_valid got=%b exp=0", out_valid); end
    checks++; if (rf_read_addr1 !== 4'd3 || rf_read_addr2 !== 4'd5) begin errors++; $display("FAIL basic_addr_hold got=%h/%h exp=3/5", rf_read_addr1, rf_read_addr2); end
    tick();
    rf_read_value1 = 32'h99; rf_read_value2 = 32'h99;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (out_op1 !== 32'h11 || out_op2 !== 32'h22) begin errors++; $display("FAIL basic_ops got=%h/%h exp=11/22", out_op1, out_op2); end
    checks++; if (out_tag !== 32'hCAFE) begin errors++; $display("FAIL basic_tag got=%h exp=cafe", out_tag); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready got=%b exp=0", in_ready); end
    out_ready = 1;
    tick();
    out_ready = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_drain got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_pc();
    quiet(); request(4'd15, 4'd2, 32'h100, 32'h15);
    tick();
    in_valid = 0; rf_read_value1 = 32'hDEAD; rf_read_value2 = 32'h77;
    wb_enable = 1; wb_addr = 4'd15; wb_value = 32'h5555;
    tick();
    @(negedge clk);
    checks++; if (out_op1 !== 32'h108 || out_op2 !== 32'h77) begin errors++; $display("FAIL pc_ops got=%h/%h exp=108/77", out_op1, out_op2); end
    tick();
    @(negedge clk);
    checks++; if (out_op1 !== 32'h108 || out_valid !== 1'b1) begin errors++; $display("FAIL pc_hold_nofwd got=%h/%b exp=108/1", out_op1, out_valid); end
    wb_enable = 0; out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_forward();
    quiet(); request(4'd4, 4'd6, 32'h300, 32'h44);
    tick();
    in_valid = 0; rf_read_value1 = 32'h01; rf_read_value2 = 32'h66;
    wb_enable = 1; wb_addr = 4'd4; wb_value = 32'hAA;
    tick();
    wb_enable = 0; rf_read_value1 = 32'h0;
    @(negedge clk);
    checks++; if (out_op1 !== 32'hAA || out_op2 !== 32'h66) begin errors++; $display("FAIL fwd_read got=%h/%h exp=aa/66", out_op1, out_op2); end
    tick();
    wb_enable = 1; wb_addr = 4'd4; wb_value = 32'hBB;
    @(negedge clk);
    checks++; if (out_op1 !== 32'hAA) begin errors++; $display("FAIL fwd_before_edge got=%h exp=aa", out_op1); end
    tick();
    wb_enable = 0;
    @(negedge clk);
    checks++; if (out_op1 !== 32'hBB || out_op2 !== 32'h66 || out_valid !== 1'b1) begin errors++; $display("FAIL fwd_hold got=%h/%h/%b exp=bb/66/1", out_op1, out_op2, out_valid); end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    quiet(); request(4'd1, 4'd2, 32'h400, 32'h1);
    tick();
    in_valid = 0; rf_read_value1 = 32'h10; rf_read_value2 = 32'h20;
    tick();
    out_ready = 1; request(4'd7, 4'd8, 32'h404, 32'h2);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b/%b exp=1/1", out_valid, in_ready); end
    checks++; if (out_op1 !== 32'h10 || out_tag !== 32'h1) begin errors++; $display("FAIL b2b_first_data got=%h/%h exp=10/1", out_op1, out_tag); end
    checks++; if (rf_read_addr1 !== 4'd7 || rf_read_addr2 !== 4'd8) begin errors++; $display("FAIL b2b_addr got=%h/%h exp=7/8", rf_read_addr1, rf_read_addr2); end
    tick();
    in_valid = 0; out_ready = 0; rf_read_value1 = 32'h70; rf_read_value2 = 32'h80;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%b exp=0", out_valid); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_op1 !== 32'h70 || out_op2 !== 32'h80 || out_tag !== 32'h2) begin errors++; $display("FAIL b2b_second got=%b/%h/%h/%h exp=1/70/80/2", out_valid, out_op1, out_op2, out_tag); end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_flush();
    quiet(); request(4'd3, 4'd4, 32'h500, 32'h5);
    tick();
    in_valid = 0; flush = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_read_ready got=%b exp=0", in_ready); end
    tick();
    flush = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_read_after got=%b/%b exp=0/1", out_valid, in_ready); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_read_never got=%b exp=0", out_valid); end
    request(4'd3, 4'd4, 32'h600, 32'h6);
    tick();
    in_valid = 0;
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_hold got=%b exp=1", out_valid); end
    flush = 1; out_ready = 1; request(4'd1, 4'd1, 32'h700, 32'h7);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_hold_ready got=%b exp=0", in_ready); end
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_hold_after got=%b/%b exp=0/1", out_valid, in_ready); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold_stays got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_hold();
    quiet(); request(4'd9, 4'd10, 32'h800, 32'h99);
    tick();
    in_valid = 0; rf_read_value1 = 32'h123; rf_read_value2 = 32'h456;
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_op1 !== 32'h123) begin errors++; $display("FAIL rh_pre got=%b/%h exp=1/123", out_valid, out_op1); end
    reset = 1; flush = 1; out_ready = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rh_ready got=%b exp=0", in_ready); end
    tick();
    reset = 0; flush = 0; out_ready = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rh_valid got=%b exp=0", out_valid); end
    checks++; if (out_op1 !== 32'd0 || out_op2 !== 32'd0 || out_tag !== 32'd0) begin errors++; $display("FAIL rh_outputs got=%h/%h/%h exp=0", out_op1, out_op2, out_tag); end
    checks++; if (rf_read_addr1 !== 4'd0 || rf_read_addr2 !== 4'd0) begin errors++; $display("FAIL rh_addr got=%h/%h exp=0/0", rf_read_addr1, rf_read_addr2); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rh_in_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pc();
    test_forward();
    test_back_to_back();
    test_flush();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
